// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// through a single full-adder cell and a carry flip-flop. Results appear on
// sum/carry only at completion, flagged by a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' port selecting a - b.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Full-adder cell on the current LSBs plus the operand-load values.
  always_comb begin
    bit_s     = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    bit_c     = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
    acc_shift = acc_q >> 1;
    acc_shift[WIDTH-1] = bit_s;
`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert b and inject the +1 through the carry.
    b_load    = sub ? ~b : b;
    c_load    = sub;
`else
    b_load    = b;
    c_load    = 1'b0;
`endif
  end

  // Next-state logic: capture in IDLE/DONE, shift-and-add in RUN.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    carry_d = carry_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        c_d    = bit_c;
        acc_d  = acc_shift;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          sum_d   = acc_shift;
          carry_d = bit_c;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      carry_q <= carry_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance checked every cycle
// against a countdown/arithmetic model, and a 1-bit instance checked directly.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub_v = 1'b0;
`endif
  logic       busy, done, carry;
  logic [7:0] sum;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, carry1;
  logic [0:0] sum1;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_v),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (1'b0),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .carry (carry1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_res(input logic [7:0] x, input logic [7:0] y,
                                           input logic s);
    if (s) return 9'({1'b0, x} + {1'b0, ~y} + 9'd1);
    return 9'({1'b0, x} + {1'b0, y});
  endfunction

  // Model: an accepted request yields its result WIDTH edges later.
  int         m_left = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_sum = '0;
  logic       m_carry = 1'b0;
  logic [8:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_sum   <= '0;
      m_carry <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) {m_carry, m_sum} <= m_res;
    end else begin
      m_done <= 1'b0;
      if (start) begin
`ifdef SERIAL_ADDER_SUB_EN
        m_res <= model_res(a, b, sub_v);
`else
        m_res <= model_res(a, b, 1'b0);
`endif
        m_left <= 8;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_left != 0));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_sum", 64'(sum), 64'(m_sum));
      chk("cyc_carry", 64'(carry), 64'(m_carry));
    end
  end

  // Start one 8-bit op at a negedge and wait (bounded) for done.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] es,
                     input logic ec, input bit scramble);
    int n;
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      a = 8'h12;
      b = 8'h12;
    end
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'd9);
    chk("lit_sum", 64'(sum), 64'(es));
    chk("lit_carry", 64'(carry), 64'(ec));
    @(negedge clk);
  endtask

  task automatic op1(input logic av, input logic bv, input logic es, input logic ec);
    a1 = av;
    b1 = bv;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy_run", 64'(busy1), 64'd1);
    chk("w1_done_run", 64'(done1), 64'd0);
    @(negedge clk);
    chk("w1_done", 64'(done1), 64'd1);
    chk("w1_busy_done", 64'(busy1), 64'd0);
    chk("w1_sum", 64'(sum1), 64'(es));
    chk("w1_carry", 64'(carry1), 64'(ec));
    @(negedge clk);
    chk("w1_done_clear", 64'(done1), 64'd0);
  endtask

  initial begin
    int n;
    bit saw_done;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    @(negedge clk);

    op8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    op8(8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);

    // start held high: ignored in RUN, recaptured in the DONE cycle.
    a = 8'hA5;
    b = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("held_latency", 64'(n), 64'd9);
    chk("held_sum", 64'(sum), 64'hFF);
    chk("held_carry", 64'(carry), 64'd0);
    a = 8'h80;
    b = 8'h80;
    @(negedge clk);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_latency", 64'(n), 64'd9);
    chk("b2b_sum", 64'(sum), 64'h00);
    chk("b2b_carry", 64'(carry), 64'd1);
    start = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a run.
    a = 8'h0F;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_carry", 64'(carry), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    op8(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);

    // WIDTH=1 half-adder truth table.
    op1(1'b0, 1'b0, 1'b0, 1'b0);
    op1(1'b0, 1'b1, 1'b1, 1'b0);
    op1(1'b1, 1'b0, 1'b1, 1'b0);
    op1(1'b1, 1'b1, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
    sub_v = 1'b1;
    op8(8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    sub_v = 1'b1;
    op8(8'h07, 8'h05, 8'h02, 1'b1, 1'b0);
    sub_v = 1'b0;
    op8(8'h07, 8'h05, 8'h0C, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder that succeeds the combinational half-adder cell. It adds two WIDTH-bit operands LSB-first, one bit per clock, through a single adder cell and a carry flip-flop, under a start/busy/done handshake. It trades latency for area and is the arithmetic leaf for the lab's multi-cycle datapaths.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low. This is the block's single clock/reset pair.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the capture edge only.
- b  input  WIDTH  operand B; sampled on the capture edge only.
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN defined.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when sum/carry take a new result.
- sum  output  WIDTH  registered result; holds until the next completion.
- carry  output  1  registered carry-out; holds until the next completion.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 on an edge (the capture edge):
  - a and b load into shift registers.
  - Carry flip-flop clears.
  - Bit counter clears to 0.
  - State goes to RUN.
- IDLE with start=0: remain in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - s = a_sr[0]^b_sr[0]^c.
  - c <= majority(a_sr[0], b_sr[0], c).
  - s shifts into the MSB of the internal accumulator register; a_sr and b_sr shift right.
  - Counter increments.
- RUN, edge processing bit WIDTH-1:
  - sum <= final accumulator value, including that edge's bit.
  - carry <= final carry.
  - State goes to DONE.
- start during RUN is ignored. It is not queued.
- sum and carry never show partial results. They change only on the completion edge.
- Arithmetic: {carry,sum} = a + b, exact over WIDTH+1 bits. No saturation.
- Bit counter width is $clog2(WIDTH) with a minimum of 1.

## Timing
- Reset (rst_n=0, asynchronous, any state):
  - State goes to IDLE.
  - sum=0, carry=0, done=0, busy=0.
  - Shift registers, counter and carry flip-flop clear.
- Reset mid-RUN aborts the operation. No done is produced, and sum/carry read 0.
- Latency: with the capture edge as E0, the completion edge is E_WIDTH. done is high from E_WIDTH to E_WIDTH+1.
- busy is high from E0 to E_WIDTH, i.e. exactly WIDTH cycles.
- Back-to-back operation: start=1 in the DONE cycle captures on E_WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- WIDTH=1: busy lasts 1 cycle; done is high from E1 to E2.
- a and b may change freely after the capture edge without effect.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Port sub exists and is captured with the operands.
  - sub=1 inverts b on capture and presets the carry flip-flop to 1.
  - The result is then sum = (a - b) mod 2^WIDTH, with carry = 1 when a >= b (no borrow).
  - sub=0 behaves exactly as addition.
- SERIAL_ADDER_SUB_EN undefined: port sub is absent, and the block performs addition only.

## Test plan
- WIDTH=8, a=0x00, b=0x00 -> sum=0x00, carry=0. done pulses exactly 8 edges after capture; busy is high for 8 cycles.
- WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, carry=1. a/b are changed to 0x12 after capture with no effect on the result.
- WIDTH=8, a=0xA5, b=0x5A, start held high throughout:
  - Result sum=0xFF, carry=0.
  - start during RUN is ignored.
  - A recapture in the DONE cycle with a=0x80, b=0x80 gives sum=0x00, carry=1, 8 edges later.
- Reset pulse at the 4th RUN cycle of a=0x0F, b=0x01:
  - Outputs go to 0 immediately and no done pulse occurs.
  - A following a=0x0F, b=0x01 gives sum=0x10, carry=0.
- WIDTH=1, all four a/b combinations -> half-adder truth table (1+1 gives sum=0, carry=1). done arrives 1 edge after capture.
- SERIAL_ADDER_SUB_EN, WIDTH=8:
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, carry=0.
  - a=0x07, b=0x05, sub=1 -> sum=0x02, carry=1.
